// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the default baud divisor.
package uart_pkg;

    // 50 MHz system clock divided down to 115200 baud.
    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input; resets to 1 so no false edge is seen.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values of the two stages: the input walks one stage per clock.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser stages, both preset to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: serial rx in, DATA_BITS word out with valid/ready handshake.
// Build option: define UART_RX_PARITY_EN to add a parity bit between data and stop.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_param: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
        $error("uart_rx_param: DATA_BITS must be 5..8");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
        $error("uart_rx_param: PARITY_ODD must be 0 or 1");
    end

    uart_state_e state_q, state_d;
    logic                 rx_s;
    logic                 rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 mid_tick;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                 par_bad_q, par_bad_d;
`endif

    uart_sync2 u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // The start bit is checked half a bit in; every later bit one full bit after the previous sample.
    assign mid_tick = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame sequencing driven by the synchronised line and the baud tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) state_d = START;
            end
            START: begin
                if (mid_tick) state_d = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (mid_tick && bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_tick) state_d = STOP;
            end
`endif
            STOP: begin
                if (mid_tick) state_d = rx_s ? IDLE : BREAK;
            end
            BREAK: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and outputs: baud/bit counting, shifting, frame checks and word delivery.
    always_comb begin
        rx_prev_d     = rx_s;
        cnt_d         = cnt_q + CNT_W'(1);
        bit_d         = bit_q;
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q && !rx_ready;
        frame_err_d   = 1'b0;
        parity_err_d  = 1'b0;
        overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d     = par_bad_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
            START: begin
                if (mid_tick) cnt_d = '0;
            end
            DATA: begin
                if (mid_tick) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (mid_tick) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ (^shift_q) ^ PAR_ODD;
                end
            end
`endif
            STOP: begin
                if (mid_tick) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
`endif
                    end else if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        overrun_err_d = 1'b1;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_q     <= 1'b1;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            parity_err_q  <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= 1'b0;
`endif
        end else begin
            rx_prev_q     <= rx_prev_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            parity_err_q  <= parity_err_d;
            overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q     <= par_bad_d;
`endif
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign parity_err  = parity_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: frame-level reference model plus per-cycle output comparison.
module tb_uart_rx_param;

    localparam int CLKS = 16;
    localparam int HALF = CLKS / 2;
    localparam int NBITS = 8;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Start edge driven at cycle n: mid-stop lies (1+NBITS+PBITS)*CLKS+HALF later,
    // plus two synchroniser stages and one output register.
    localparam int LAT = (1 + NBITS + PBITS) * CLKS + HALF + 3;

    localparam int EV_DELIVER = 0;
    localparam int EV_FRAME   = 1;
    localparam int EV_PAR     = 2;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;

    logic readyFix;
    logic randReady;
    logic rndReady;
    logic checkEn;

    int checks = 0;
    int passes = 0;
    int cycle = 0;

    ev_t        evq[$];
    logic       mdlValid = 1'b0;
    logic [7:0] mdlData = 8'h00;
    logic       expFrame = 1'b0;
    logic       expPar = 1'b0;
    logic       expOvr = 1'b0;

    int   riseCycle = 0;
    int   validRises = 0;
    int   validCycles = 0;
    int   frameCnt = 0;
    int   parCnt = 0;
    int   ovrCnt = 0;
    logic prevValid = 1'b0;

    assign rx_ready = randReady ? rndReady : readyFix;

    uart_rx_param #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (NBITS),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Consumer that randomly accepts or stalls, used during the random phase.
    always @(posedge clk) begin
        #1;
        rndReady = ($urandom_range(0, 1) == 1);
    end

    function automatic logic parOf(input logic [7:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearObs();
        validRises  = 0;
        validCycles = 0;
        frameCnt    = 0;
        parCnt      = 0;
        ovrCnt      = 0;
    endtask

    // Send one frame starting now; the model decides what the receiver must report and when.
    task automatic applyStimulus(input logic [7:0] d, input logic stopVal, input logic parBit,
                                 input int lowHold, input int rstBit);
        ev_t  ev;
        logic parBad;
        parBad  = (PBITS == 1) && (parBit != parOf(d));
        ev.at   = cycle + LAT;
        ev.data = d;
        if (!stopVal)    ev.kind = EV_FRAME;
        else if (parBad) ev.kind = EV_PAR;
        else             ev.kind = EV_DELIVER;
        evq.push_back(ev);
        rx = 1'b0;
        idle(CLKS);
        for (int i = 0; i < NBITS; i++) begin
            rx = d[i];
            if (i == rstBit) begin
                idle(HALF);
                rst = 1'b1;
                idle(2);
                rst = 1'b0;
                idle(CLKS - HALF - 2);
            end else begin
                idle(CLKS);
            end
        end
        if (PBITS == 1) begin
            rx = parBit;
            idle(CLKS);
        end
        rx = stopVal;
        idle(CLKS);
        if (lowHold > 0) begin
            rx = 1'b0;
            idle(lowHold);
        end
        rx = 1'b1;
    endtask

    // Reference model: applies the reset, handshake and delivery rules at each clock edge.
    always @(posedge clk) begin
        logic vPre;
        logic rPre;
        ev_t  ev;
        cycle++;
        expFrame = 1'b0;
        expPar   = 1'b0;
        expOvr   = 1'b0;
        if (rst) begin
            evq.delete();
            mdlValid = 1'b0;
            mdlData  = 8'h00;
        end else begin
            vPre = mdlValid;
            rPre = rx_ready;
            if (vPre && rPre) mdlValid = 1'b0;
            if (evq.size() > 0 && evq[0].at == cycle) begin
                ev = evq.pop_front();
                case (ev.kind)
                    EV_FRAME: expFrame = 1'b1;
                    EV_PAR:   expPar = 1'b1;
                    default: begin
                        if (!vPre || rPre) begin
                            mdlData  = ev.data;
                            mdlValid = 1'b1;
                        end else begin
                            expOvr = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Compare every DUT output with the model mid-cycle and log observed events.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("rx_valid", 32'(rx_valid), 32'(mdlValid));
            checkOutput("rx_data", 32'(rx_data), 32'(mdlData));
            checkOutput("frame_err", 32'(frame_err), 32'(expFrame));
            checkOutput("parity_err", 32'(parity_err), 32'(expPar));
            checkOutput("overrun_err", 32'(overrun_err), 32'(expOvr));
            if (rx_valid && !prevValid) begin
                riseCycle = cycle;
                validRises++;
            end
            if (rx_valid) validCycles++;
            if (frame_err) frameCnt++;
            if (parity_err) parCnt++;
            if (overrun_err) ovrCnt++;
            prevValid = rx_valid;
        end
    end

    // Run-time bound.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int t0;
        logic [7:0] d;
        logic bad;
        logic pbad;
        rst       = 1'b1;
        rx        = 1'b1;
        readyFix  = 1'b1;
        randReady = 1'b0;
        checkEn   = 1'b0;
        idle(1);
        checkEn = 1'b1;
        idle(2);
        @(negedge clk);
        checkOutput("reset_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'h00);
        checkOutput("reset_errs", 32'({frame_err, parity_err, overrun_err}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        $display("[TB] test 1: 0xA5");
        clearObs();
        t0 = cycle;
        applyStimulus(8'hA5, 1'b1, parOf(8'hA5), 0, -1);
        idle(20);
        checkOutput("t1_latency", 32'(riseCycle - t0), (PBITS == 1) ? 32'd171 : 32'd155);
        checkOutput("t1_rises", 32'(validRises), 32'd1);
        checkOutput("t1_valid_cycles", 32'(validCycles), 32'd1);
        checkOutput("t1_data", 32'(rx_data), 32'hA5);
        checkOutput("t1_errs", 32'(frameCnt + parCnt + ovrCnt), 32'd0);

        $display("[TB] test 2: glitch");
        clearObs();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(40);
        checkOutput("t2_rises", 32'(validRises), 32'd0);
        checkOutput("t2_errs", 32'(frameCnt + parCnt + ovrCnt), 32'd0);

        $display("[TB] test 3: framing error and break");
        clearObs();
        applyStimulus(8'h3C, 1'b0, parOf(8'h3C), 40, -1);
        idle(10);
        checkOutput("t3_frame_cnt", 32'(frameCnt), 32'd1);
        checkOutput("t3_rises", 32'(validRises), 32'd0);
        applyStimulus(8'h55, 1'b1, parOf(8'h55), 0, -1);
        idle(10);
        checkOutput("t3_data", 32'(rx_data), 32'h55);
        checkOutput("t3_rises2", 32'(validRises), 32'd1);

        $display("[TB] test 4: overrun");
        clearObs();
        readyFix = 1'b0;
        applyStimulus(8'h11, 1'b1, parOf(8'h11), 0, -1);
        applyStimulus(8'h22, 1'b1, parOf(8'h22), 0, -1);
        idle(10);
        checkOutput("t4_valid_held", 32'(rx_valid), 32'd1);
        checkOutput("t4_data", 32'(rx_data), 32'h11);
        checkOutput("t4_ovr_cnt", 32'(ovrCnt), 32'd1);
        readyFix = 1'b1;
        idle(1);
        @(negedge clk);
        checkOutput("t4_valid_fall", 32'(rx_valid), 32'd0);
        idle(10);

`ifdef UART_RX_PARITY_EN
        $display("[TB] test 5: parity");
        clearObs();
        applyStimulus(8'h07, 1'b1, 1'b1, 0, -1);
        idle(10);
        checkOutput("t5_data", 32'(rx_data), 32'h07);
        checkOutput("t5_rises", 32'(validRises), 32'd1);
        applyStimulus(8'h07, 1'b1, 1'b0, 0, -1);
        idle(10);
        checkOutput("t5_par_cnt", 32'(parCnt), 32'd1);
        checkOutput("t5_rises2", 32'(validRises), 32'd1);
`endif

        $display("[TB] test 6: reset mid-frame");
        clearObs();
        applyStimulus(8'hFF, 1'b1, parOf(8'hFF), 0, 3);
        idle(20);
        checkOutput("t6_no_word", 32'(validRises), 32'd0);
        applyStimulus(8'h81, 1'b1, parOf(8'h81), 0, -1);
        idle(10);
        checkOutput("t6_rises", 32'(validRises), 32'd1);
        checkOutput("t6_data", 32'(rx_data), 32'h81);

        $display("[TB] random frames");
        randReady = 1'b1;
        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            bad  = ($urandom_range(0, 7) == 0);
            pbad = (PBITS == 1) && ($urandom_range(0, 7) == 0);
            applyStimulus(d, !bad, parOf(d) ^ pbad, bad ? int'($urandom_range(0, 20)) : 0, -1);
            idle(bad ? int'($urandom_range(6, 16)) : int'($urandom_range(0, 10)));
        end
        randReady = 1'b0;
        readyFix  = 1'b1;
        idle(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
